rgmii_rx_decoder: RTL and testbench
===================================

Name: rgmii_rx_decoder

Overview:
- Multi-speed RGMII receive decoder. It sits between the per-pin IDDR capture stage (5 lanes: ctl plus 4 data, rise and fall outputs) and the GMII-side MAC receive logic.
- Decodes RX_DV/RX_ER from the RGMII ctl encoding and assembles bytes in 10/100 nibble mode.
- Extracts in-band link status during inter-frame gaps and keeps saturating frame/error counters.
- All logic runs in the recovered receive clock domain.

Parameters:
- STATUS_STABLE, 4: consecutive identical idle in-band samples required before link status updates (range 1..15).
- CNT_W, 16: width of the frame and error counters.
- INBAND_EN, 1: 1 enables in-band status decode; 0 holds link outputs at reset values.

Ports:
- gmii_rx_clk, input, 1: receive clock; all logic on its rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- ddr_rise, input, 5: IDDR rising-edge samples; bit4 = ctl, [3:0] = data.
- ddr_fall, input, 5: IDDR falling-edge samples, aligned to ddr_rise; same bit layout.
- speed_mode, input, 2: 00 = 10M, 01 = 100M, 10 = 1000M, 11 = treated as 1000M.
- gmii_rx_ce, output, 1: byte-valid strobe; gmii_rx_dv, gmii_rx_er and gmii_rxd are meaningful only when it is high.
- gmii_rx_dv, output, 1: data valid.
- gmii_rx_er, output, 1: receive error.
- gmii_rxd, output, 8: received byte.
- link_up, output, 1: in-band link status.
- link_speed, output, 2: in-band speed, same encoding as speed_mode.
- link_duplex, output, 1: in-band duplex, 1 = full.
- rx_frame_cnt, output, CNT_W: frames received, saturating.
- rx_err_cnt, output, CNT_W: frames containing at least one error, saturating.

Behaviour:
- Reset: every output is 0, the FSM is in IDLE, counters and the stability counter are 0, and the active speed is 1000M. Reset is asynchronous and may land mid-frame; the partial frame is discarded and not counted.
- Per-cycle decode: dv = ddr_rise[4]; er = ddr_rise[4] ^ ddr_fall[4].
- Active speed:
  - speed_mode is latched into the active-speed register only on cycles where decoded dv = 0.
  - A change while dv = 1 is deferred to the first dv = 0 cycle.
- 1000M mode:
  - gmii_rx_ce = 1 every cycle.
  - gmii_rxd = {ddr_fall[3:0], ddr_rise[3:0]}, gmii_rx_dv = dv, gmii_rx_er = er.
  - All registered, latency 1 cycle.
  - Carrier extension (dv=0, er=1, data 0x0F) and false carrier (0x0E) are passed through unchanged.
- 10/100M mode: only ddr_rise data is used. FSM states:
  - IDLE: waits for dv = 1. On dv = 1, captures nibble L = ddr_rise[3:0] and er_acc = er, then goes to HIGH.
  - HIGH:
    - If dv = 1, emits a byte {ddr_rise[3:0], L} with gmii_rx_er = er_acc | er, gmii_rx_dv = 1 and gmii_rx_ce pulsed, then goes to LOW.
    - If dv = 0 (odd nibble count), emits a byte {4'h0, L} with gmii_rx_dv = 1, gmii_rx_er = 1 and a ce pulse, marks the frame as errored, then goes to IDLE.
  - LOW: if dv = 1, captures L and er_acc, then goes to HIGH; if dv = 0, goes to IDLE.
  - Byte latency: ce is asserted the cycle after the high-nibble sample.
  - gmii_rx_ce = 0 on all other cycles.
- Frame end: detected on the dv 1→0 transition (any mode).
  - rx_frame_cnt increments.
  - rx_err_cnt increments if any er was seen during dv = 1 or the frame had an odd nibble count.
  - Both counters saturate at all-ones.
- In-band status (INBAND_EN = 1):
  - Sampled only on cycles with ddr_rise[4] = 0 and ddr_fall[4] = 0. The sample is ddr_rise[3:0]: bit0 = link, bits[2:1] = speed, bit3 = duplex.
  - A sample equal to the previous one increments the stability counter, saturating at 15; a different sample resets it to 1.
  - When the count reaches STATUS_STABLE, the sample is copied to link_up, link_speed and link_duplex.
  - Cycles that do not qualify (dv or er set) hold the stability counter.
- link_* outputs never drive active speed; software or the MAC uses them to set speed_mode.

Test Plan:
- 1000M, 8× 0x55, 0xD5, 64 bytes 0x00..0x3F, clean ctl → 73 ce bytes identical in order, dv = 1, er = 0, 1-cycle latency; rx_frame_cnt = 1, rx_err_cnt = 0.
- 100M, nibble stream 5,5,…,5,D then pairs for 0xA1, 0xB2 → bytes 0x55…, 0xD5, 0xA1, 0xB2, one ce pulse every 2 cycles.
- 100M, frame with 7 nibbles → last byte {0, L} with er = 1; rx_err_cnt = 1.
- 1000M, ddr_fall[4] = 0 mid-frame for one cycle → that byte has er = 1; rx_err_cnt increments once at frame end.
- Idle, in-band 4'b1101 held 4 cycles → link_up = 1, link_speed = 10, link_duplex = 1 after the 4th cycle. A glitch after 3 cycles leaves outputs unchanged.
- speed_mode 10 → 01 during a frame → bytes stay in 1000M format until dv drops; the next frame uses nibble mode. Also: assert rst_n low mid-frame → all outputs 0 and no count.

Source files
------------

// File: rtl/rgmii_rx_decoder_if.sv
// GMII-side receive bus produced by the RGMII receive decoder.
//   gmii_rx_ce  : byte-valid strobe; dv/er/rxd are meaningful only while high
//   gmii_rx_dv  : data valid
//   gmii_rx_er  : receive error
//   gmii_rxd    : received byte
// master drives the bus (decoder), slave consumes it (MAC receive logic).
interface rgmii_rx_decoder_if;
  logic       gmii_rx_ce;
  logic       gmii_rx_dv;
  logic       gmii_rx_er;
  logic [7:0] gmii_rxd;

  modport master (
    output gmii_rx_ce,
    output gmii_rx_dv,
    output gmii_rx_er,
    output gmii_rxd
  );

  modport slave (
    input gmii_rx_ce,
    input gmii_rx_dv,
    input gmii_rx_er,
    input gmii_rxd
  );
endinterface

// File: rtl/rgmii_rx_decoder.sv
// Multi-speed RGMII receive decoder (10/100/1000M), receive clock domain only.
// Decodes RX_DV/RX_ER from the ctl lane, passes bytes straight through at 1000M and
// assembles nibble pairs at 10/100M, extracts in-band link status during idle and keeps
// saturating frame / errored-frame counters.
// Ports:
//   gmii_rx_clk  : receive clock (rising edge)
//   rst_n        : asynchronous active-low reset
//   ddr_rise     : IDDR rising-edge samples, [4] = ctl, [3:0] = data
//   ddr_fall     : IDDR falling-edge samples, same layout
//   speed_mode   : 00 = 10M, 01 = 100M, 1x = 1000M
//   gmii         : GMII receive bus (ce/dv/er/rxd), master side
//   link_up, link_speed, link_duplex : in-band status
//   rx_frame_cnt, rx_err_cnt         : saturating frame / errored-frame counters
module rgmii_rx_decoder #(
  parameter int unsigned STATUS_STABLE = 4,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned INBAND_EN     = 1
) (
  input  logic                 gmii_rx_clk,
  input  logic                 rst_n,
  input  logic [4:0]           ddr_rise,
  input  logic [4:0]           ddr_fall,
  input  logic [1:0]           speed_mode,
  rgmii_rx_decoder_if.master   gmii,
  output logic                 link_up,
  output logic [1:0]           link_speed,
  output logic                 link_duplex,
  output logic [CNT_W-1:0]     rx_frame_cnt,
  output logic [CNT_W-1:0]     rx_err_cnt
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StHigh  = 2'd1;
  localparam logic [1:0] StLow   = 2'd2;
  localparam logic [1:0] Spd10M  = 2'b00;
  localparam logic [1:0] Spd100M = 2'b01;
  localparam logic [3:0] StableThr = 4'(STATUS_STABLE);

  logic [1:0]       r_speed;
  logic [1:0]       r_state, w_state_d;
  logic [3:0]       r_nib, w_nib_d;
  logic             r_er_acc, w_er_acc_d;
  logic             r_ce, r_dv, r_er;
  logic [7:0]       r_rxd;
  logic             w_ce_d, w_dv_d, w_er_d;
  logic [7:0]       w_rxd_d;
  logic             r_dv_prev, r_in_frame, w_in_frame_d;
  logic             r_frame_err, w_frame_err_d;
  logic [CNT_W-1:0] r_frame_cnt, w_frame_cnt_d, r_err_cnt, w_err_cnt_d;
  logic [3:0]       r_ib_prev, w_ib_prev_d, r_stab, w_stab_d;
  logic             r_link_up, w_link_up_d, r_link_duplex, w_link_duplex_d;
  logic [1:0]       r_link_speed, w_link_speed_d;

  logic       w_dv, w_er, w_gig, w_odd, w_frame_end, w_ib_ok;
  logic [3:0] w_sample;

  assign w_dv     = ddr_rise[4];
  assign w_er     = ddr_rise[4] ^ ddr_fall[4];
  assign w_gig    = (r_speed != Spd10M) && (r_speed != Spd100M);
  assign w_ib_ok  = ~ddr_rise[4] & ~ddr_fall[4];
  assign w_sample = ddr_rise[3:0];

  // r_dv_prev resets to 1 so a frame already in flight at reset release is never
  // treated as a new frame start and therefore never counted.
  assign w_frame_end   = r_in_frame & ~w_dv;
  assign w_in_frame_d  = w_dv & (r_in_frame | ~r_dv_prev);
  assign w_frame_err_d = w_in_frame_d & (r_frame_err | w_er);

  // Byte path: 1000M passthrough or 10/100M nibble assembly.
  always_comb begin
    w_state_d  = r_state;
    w_nib_d    = r_nib;
    w_er_acc_d = r_er_acc;
    w_ce_d     = 1'b0;
    w_dv_d     = 1'b0;
    w_er_d     = 1'b0;
    w_rxd_d    = 8'h00;
    w_odd      = 1'b0;
    if (w_gig) begin
      w_state_d = StIdle;
      w_ce_d    = 1'b1;
      w_dv_d    = w_dv;
      w_er_d    = w_er;
      w_rxd_d   = {ddr_fall[3:0], ddr_rise[3:0]};
    end else begin
      case (r_state)
        StHigh: begin
          w_ce_d = 1'b1;
          w_dv_d = 1'b1;
          if (w_dv) begin
            w_er_d    = r_er_acc | w_er;
            w_rxd_d   = {ddr_rise[3:0], r_nib};
            w_state_d = StLow;
          end else begin
            // Frame ended on an odd nibble: flush the lone nibble as an errored byte.
            w_er_d    = 1'b1;
            w_rxd_d   = {4'h0, r_nib};
            w_odd     = 1'b1;
            w_state_d = StIdle;
          end
        end
        default: begin  // StIdle and StLow behave identically
          if (w_dv) begin
            w_nib_d    = ddr_rise[3:0];
            w_er_acc_d = w_er;
            w_state_d  = StHigh;
          end else begin
            w_state_d  = StIdle;
          end
        end
      endcase
    end
  end

  // Frame counters and in-band status.
  always_comb begin
    w_frame_cnt_d   = r_frame_cnt;
    w_err_cnt_d     = r_err_cnt;
    w_ib_prev_d     = r_ib_prev;
    w_stab_d        = r_stab;
    w_link_up_d     = r_link_up;
    w_link_speed_d  = r_link_speed;
    w_link_duplex_d = r_link_duplex;
    if (w_frame_end) begin
      if (r_frame_cnt != '1) w_frame_cnt_d = r_frame_cnt + CNT_W'(1);
      if ((r_frame_err || w_odd) && (r_err_cnt != '1)) w_err_cnt_d = r_err_cnt + CNT_W'(1);
    end
    if (w_ib_ok) begin
      w_ib_prev_d = w_sample;
      if (w_sample != r_ib_prev) w_stab_d = 4'd1;
      else if (r_stab != 4'hF)   w_stab_d = r_stab + 4'd1;
      if ((INBAND_EN != 0) && (w_stab_d >= StableThr)) begin
        w_link_up_d     = w_sample[0];
        w_link_speed_d  = w_sample[2:1];
        w_link_duplex_d = w_sample[3];
      end
    end
  end

  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_speed       <= 2'b10;
      r_state       <= StIdle;
      r_nib         <= 4'h0;
      r_er_acc      <= 1'b0;
      r_ce          <= 1'b0;
      r_dv          <= 1'b0;
      r_er          <= 1'b0;
      r_rxd         <= 8'h00;
      r_dv_prev     <= 1'b1;
      r_in_frame    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_frame_cnt   <= '0;
      r_err_cnt     <= '0;
      r_ib_prev     <= 4'h0;
      r_stab        <= 4'h0;
      r_link_up     <= 1'b0;
      r_link_speed  <= 2'b00;
      r_link_duplex <= 1'b0;
    end else begin
      if (!w_dv) r_speed <= speed_mode;  // speed changes only take effect between frames
      r_state       <= w_state_d;
      r_nib         <= w_nib_d;
      r_er_acc      <= w_er_acc_d;
      r_ce          <= w_ce_d;
      r_dv          <= w_dv_d;
      r_er          <= w_er_d;
      r_rxd         <= w_rxd_d;
      r_dv_prev     <= w_dv;
      r_in_frame    <= w_in_frame_d;
      r_frame_err   <= w_frame_err_d;
      r_frame_cnt   <= w_frame_cnt_d;
      r_err_cnt     <= w_err_cnt_d;
      r_ib_prev     <= w_ib_prev_d;
      r_stab        <= w_stab_d;
      r_link_up     <= w_link_up_d;
      r_link_speed  <= w_link_speed_d;
      r_link_duplex <= w_link_duplex_d;
    end
  end

  assign gmii.gmii_rx_ce = r_ce;
  assign gmii.gmii_rx_dv = r_dv;
  assign gmii.gmii_rx_er = r_er;
  assign gmii.gmii_rxd   = r_rxd;
  assign link_up         = r_link_up;
  assign link_speed      = r_link_speed;
  assign link_duplex     = r_link_duplex;
  assign rx_frame_cnt    = r_frame_cnt;
  assign rx_err_cnt      = r_err_cnt;

endmodule

// File: tb/tb_rgmii_rx_decoder.sv
// Directed self-checking bench for rgmii_rx_decoder.
module tb_rgmii_rx_decoder;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ddr_rise;
  logic [4:0]  ddr_fall;
  logic [1:0]  speed_mode;
  logic        link_up;
  logic [1:0]  link_speed;
  logic        link_duplex;
  logic [15:0] rx_frame_cnt;
  logic [15:0] rx_err_cnt;

  int n_vec = 0;
  int n_err = 0;

  rgmii_rx_decoder_if gmii_if ();

  rgmii_rx_decoder #(
    .STATUS_STABLE (4),
    .CNT_W         (16),
    .INBAND_EN     (1)
  ) dut (
    .gmii_rx_clk  (clk),
    .rst_n        (rst_n),
    .ddr_rise     (ddr_rise),
    .ddr_fall     (ddr_fall),
    .speed_mode   (speed_mode),
    .gmii         (gmii_if),
    .link_up      (link_up),
    .link_speed   (link_speed),
    .link_duplex  (link_duplex),
    .rx_frame_cnt (rx_frame_cnt),
    .rx_err_cnt   (rx_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of IDDR samples; outputs are inspected 1 time unit after the edge.
  task automatic cyc(input logic [4:0] r, input logic [4:0] f);
    ddr_rise = r;
    ddr_fall = f;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(5'h00, 5'h00);
  endtask

  task automatic gig_byte(input logic [7:0] b, input logic err);
    cyc({1'b1, b[3:0]}, {~err, b[7:4]});
  endtask

  task automatic test_reset();
    #3;
    if ({gmii_if.gmii_rx_ce, gmii_if.gmii_rx_dv, gmii_if.gmii_rx_er, gmii_if.gmii_rxd,
         link_up, link_speed, link_duplex, rx_frame_cnt, rx_err_cnt} !== 47'd0) begin
      $display("FAIL reset_outputs: got ce=%b dv=%b er=%b rxd=%h link=%b/%b/%b cnt=%0d/%0d need all 0",
               gmii_if.gmii_rx_ce, gmii_if.gmii_rx_dv, gmii_if.gmii_rx_er, gmii_if.gmii_rxd,
               link_up, link_speed, link_duplex, rx_frame_cnt, rx_err_cnt);
      n_err++;
    end
    n_vec++;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_link(input string name, input logic [3:0] exp);
    if ({link_duplex, link_speed, link_up} !== exp) begin
      $display("FAIL %s: got {dup,spd,up}=%b need %b", name, {link_duplex, link_speed, link_up}, exp);
      n_err++;
    end
    n_vec++;
  endtask

  task automatic test_inband();
    for (int i = 0; i < 3; i++) cyc(5'b0_1101, 5'b0_0000);
    cyc(5'b0_0000, 5'b0_0000);               // glitch after 3 stable samples
    check_link("inband_glitch", 4'b0000);
    cyc(5'b0_1101, 5'b0_0000);
    cyc(5'b0_1101, 5'b0_0000);
    cyc(5'b0_0010, 5'b1_0000);               // er set: not sampled, count held at 2
    cyc(5'b0_1101, 5'b0_0000);
    check_link("inband_count3", 4'b0000);
    cyc(5'b0_1101, 5'b0_0000);
    check_link("inband_count4", 4'b1101);
  endtask

  task automatic check_cnt(input string name, input int fr, input int er);
    if (rx_frame_cnt !== 16'(fr) || rx_err_cnt !== 16'(er)) begin
      $display("FAIL %s: got frames=%0d errs=%0d need frames=%0d errs=%0d",
               name, rx_frame_cnt, rx_err_cnt, fr, er);
      n_err++;
    end
    n_vec++;
  endtask

  task automatic check_byte(input string name, input int idx, input logic [10:0] exp);
    logic [10:0] got;
    got = {gmii_if.gmii_rx_ce, gmii_if.gmii_rx_dv, gmii_if.gmii_rx_er, gmii_if.gmii_rxd};
    if (got !== exp) begin
      $display("FAIL %s[%0d]: got {ce,dv,er,rxd}=%b_%b_%b_%h need %b_%b_%b_%h", name, idx,
               got[10], got[9], got[8], got[7:0], exp[10], exp[9], exp[8], exp[7:0]);
      n_err++;
    end
    n_vec++;
  endtask

  task automatic test_gig_frame();
    logic [7:0] b;
    for (int i = 0; i < 73; i++) begin
      b = (i < 8) ? 8'h55 : (i == 8) ? 8'hD5 : 8'(i - 9);
      gig_byte(b, 1'b0);
      check_byte("gig_byte", i, {3'b110, b});
    end
    idle();
    check_byte("gig_idle", 0, 11'b100_0000_0000);
    check_cnt("gig_frame_cnt", 1, 0);
  endtask

  task automatic test_gig_error();
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = 8'hC0 + 8'(i);
      gig_byte(b, i == 2);
      check_byte("gig_err_byte", i, {2'b11, (i == 2), b});
    end
    idle();
    check_cnt("gig_err_cnt", 2, 1);
    cyc(5'b0_1111, 5'b1_0000);               // carrier extension passes through
    check_byte("carrier_ext", 0, {3'b101, 8'h0F});
    idle();
    check_cnt("carrier_ext_cnt", 2, 1);
  endtask

  task automatic test_nibble_frame();
    logic [3:0] nib [20];
    for (int i = 0; i < 15; i++) nib[i] = 4'h5;
    nib[15] = 4'hD;
    nib[16] = 4'h1; nib[17] = 4'hA;
    nib[18] = 4'h2; nib[19] = 4'hB;
    speed_mode = 2'b01;
    idle();
    for (int i = 0; i < 20; i++) begin
      cyc({1'b1, nib[i]}, {1'b1, 4'h0});
      if (i % 2 == 1) check_byte("nib_byte", i, {3'b110, nib[i], nib[i-1]});
      else            check_byte("nib_gap", i, 11'd0);
    end
    idle();
    check_cnt("nib_frame_cnt", 3, 1);
  endtask

  task automatic test_odd_nibble();
    for (int i = 1; i <= 7; i++) begin
      cyc({1'b1, 4'(i)}, {1'b1, 4'h0});
      if (i % 2 == 0) check_byte("odd_byte", i, {3'b110, 4'(i), 4'(i - 1)});
    end
    idle();
    check_byte("odd_last", 0, {3'b111, 8'h07});
    check_cnt("odd_cnt", 4, 2);
    idle();
    check_byte("odd_after", 0, 11'd0);
  endtask

  task automatic test_speed_change();
    speed_mode = 2'b10;
    idle();
    for (int i = 0; i < 6; i++) begin
      if (i == 2) speed_mode = 2'b01;         // deferred until dv drops
      gig_byte(8'h10 + 8'(i), 1'b0);
      check_byte("spd_gig_byte", i, {3'b110, 8'h10 + 8'(i)});
    end
    idle();
    check_byte("spd_gig_idle", 0, 11'b100_0000_0000);
    check_cnt("spd_cnt1", 5, 2);
    for (int i = 1; i <= 4; i++) begin
      cyc({1'b1, 4'(i)}, {1'b1, 4'h0});
      if (i % 2 == 0) check_byte("spd_nib_byte", i, {3'b110, 4'(i), 4'(i - 1)});
      else            check_byte("spd_nib_gap", i, 11'd0);
    end
    idle();
    check_cnt("spd_cnt2", 6, 2);
  endtask

  task automatic test_reset_mid_frame();
    cyc(5'b1_0011, 5'b1_0000);
    cyc(5'b1_0100, 5'b1_0000);
    cyc(5'b1_0101, 5'b1_0000);
    rst_n = 1'b0;
    #1;
    if ({gmii_if.gmii_rx_ce, gmii_if.gmii_rx_dv, gmii_if.gmii_rx_er, gmii_if.gmii_rxd,
         link_up, link_speed, link_duplex, rx_frame_cnt, rx_err_cnt} !== 47'd0) begin
      $display("FAIL midframe_reset_outputs: got ce=%b dv=%b rxd=%h link=%b cnt=%0d/%0d need all 0",
               gmii_if.gmii_rx_ce, gmii_if.gmii_rx_dv, gmii_if.gmii_rxd, link_up,
               rx_frame_cnt, rx_err_cnt);
      n_err++;
    end
    n_vec++;
    cyc(5'b1_0110, 5'b0_0000);
    rst_n = 1'b1;
    cyc(5'b1_0111, 5'b1_0000);
    cyc(5'b1_1000, 5'b0_0000);
    idle();
    idle();
    check_cnt("midframe_no_count", 0, 0);
  endtask

  initial begin
    rst_n      = 1'b1;
    ddr_rise   = 5'h00;
    ddr_fall   = 5'h00;
    speed_mode = 2'b10;
    #2 rst_n = 1'b0;
    test_reset();
    test_inband();
    test_gig_frame();
    test_gig_error();
    test_nibble_frame();
    test_odd_nibble();
    test_speed_change();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
